// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan sequencer.
package adc_pkg;
   localparam int ADC_CH_W   = 3;
   localparam int ADC_DATA_W = 12;
   localparam int ADC_NUM_CH = 8;

   typedef enum logic [1:0] {IDLE, PRIME, WAIT, ACK} adc_state_t;

   // Highest enabled channel; its result closes a pass.
   function automatic logic [ADC_CH_W-1:0] adc_msb_ch(input logic [ADC_NUM_CH-1:0] en);
      adc_msb_ch = '0;
      for (int i = 0; i < ADC_NUM_CH; i++)
         if (en[i]) adc_msb_ch = ADC_CH_W'(i);
   endfunction
endpackage

// File: rtl/adc_ch_next.sv
// Next enabled channel strictly above cur_ch, wrapping; returns cur_ch if it is the only one.
module adc_ch_next
   import adc_pkg::*;
(
   input  logic [ADC_NUM_CH-1:0] en_q,
   input  logic [ADC_CH_W-1:0]   cur_ch,
   output logic [ADC_CH_W-1:0]   next_ch
);
   logic                found;
   logic [ADC_CH_W-1:0] idx;

   always_comb begin
      next_ch = cur_ch;
      found   = 1'b0;
      idx     = cur_ch;
      for (int i = 1; i <= ADC_NUM_CH; i++) begin
         idx = cur_ch + ADC_CH_W'(i);
         if (!found && en_q[idx]) begin
            next_ch = idx;
            found   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans enabled ADC channels through a pipelined-select capture block and banks the results.
module adc_scan_sequencer
   import adc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    continuous,
   input  logic [ADC_NUM_CH-1:0]   ch_enable,
   input  logic                    adc_ready,
   input  logic [ADC_DATA_W-1:0]   d_signal,
   input  logic [ADC_CH_W-1:0]     rd_ch,
   output logic                    ctl_valid,
   output logic                    adc_ack,
   output logic [ADC_CH_W-1:0]     address,
   output logic                    busy,
   output logic                    result_valid,
   output logic [ADC_CH_W-1:0]     result_ch,
   output logic [ADC_DATA_W-1:0]   result_data,
   output logic                    scan_done,
   output logic                    err,
   output logic [ADC_DATA_W-1:0]   rd_data
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   adc_state_t                          state, state_nxt;
   logic [ADC_NUM_CH-1:0]               en_q;
   logic                                cont_q, stop_pend, done_pend;
   logic [ADC_CH_W-1:0]                 prev_addr, first_ch, next_ch;
   logic [CNT_W-1:0]                    tmo_cnt;
   logic [ADC_NUM_CH-1:0][ADC_DATA_W-1:0] bank;
   logic                                start_ok, conv, timeout, ack_exit, end_scan;

   // Searching upward from the top channel yields the lowest enabled one.
   adc_ch_next u_first (.en_q(ch_enable), .cur_ch(ADC_CH_W'(ADC_NUM_CH - 1)), .next_ch(first_ch));
   adc_ch_next u_next  (.en_q(en_q),      .cur_ch(address),                    .next_ch(next_ch));

   assign rd_data = bank[rd_ch];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      conv      = 1'b0;
      timeout   = 1'b0;
      ack_exit  = 1'b0;
      end_scan  = 1'b0;
      case (state)
         IDLE: if (start && |ch_enable) begin
            start_ok  = 1'b1;
            state_nxt = PRIME;
         end
         PRIME, WAIT: begin
            if (adc_ready) begin
               conv      = 1'b1;
               state_nxt = ACK;
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         ACK: if (!adc_ready) begin
            ack_exit  = 1'b1;
            end_scan  = stop_pend | stop | done_pend;
            state_nxt = end_scan ? IDLE : WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Restarts on every state change, so ACK and IDLE always see zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           tmo_cnt <= '0;
      else if (state_nxt != state)                       tmo_cnt <= '0;
      else if ((state == PRIME || state == WAIT) && !adc_ready) tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q         <= '0;
         cont_q       <= 1'b0;
         stop_pend    <= 1'b0;
         done_pend    <= 1'b0;
         ctl_valid    <= 1'b0;
         adc_ack      <= 1'b0;
         busy         <= 1'b0;
         address      <= '0;
         prev_addr    <= '0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_data  <= '0;
         scan_done    <= 1'b0;
         err          <= 1'b0;
         bank         <= '0;
      end else begin
         result_valid <= 1'b0;
         scan_done    <= 1'b0;
         if (start_ok) begin
            en_q      <= ch_enable;
            cont_q    <= continuous;
            err       <= 1'b0;
            address   <= first_ch;
            ctl_valid <= 1'b1;
            busy      <= 1'b1;
            stop_pend <= 1'b0;
            done_pend <= 1'b0;
         end
         if (stop && state != IDLE) stop_pend <= 1'b1;
         if (conv) begin
            // Data arriving now belongs to the channel selected one conversion earlier.
            prev_addr <= address;
            address   <= next_ch;
            adc_ack   <= 1'b1;
            if (state == WAIT) begin
               bank[prev_addr] <= d_signal;
               result_valid    <= 1'b1;
               result_ch       <= prev_addr;
               result_data     <= d_signal;
               if (prev_addr == adc_msb_ch(en_q)) begin
                  scan_done <= 1'b1;
                  if (!cont_q) done_pend <= 1'b1;
               end
            end
         end
         if (ack_exit) begin
            adc_ack <= 1'b0;
            if (end_scan) begin
               ctl_valid <= 1'b0;
               busy      <= 1'b0;
               stop_pend <= 1'b0;
               done_pend <= 1'b0;
            end
         end
         if (timeout) begin
            err       <= 1'b1;
            ctl_valid <= 1'b0;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
            done_pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench: behavioural capture block plus a pass/tagging reference model.
module tb_adc_scan_sequencer;
   import adc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, stop, continuous, adc_ready;
   logic [7:0]  ch_enable;
   logic [11:0] d_signal;
   logic [2:0]  rd_ch;
   logic        ctl_valid, adc_ack, busy, result_valid, scan_done, err;
   logic [2:0]  address, result_ch;
   logic [11:0] result_data, rd_data;

   int          checks = 0, failures = 0;
   logic [16:0] mon_q[$];
   logic [11:0] bank_m[8];

   always #5 clk = ~clk;

   adc_scan_sequencer #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
      .ch_enable(ch_enable), .adc_ready(adc_ready), .d_signal(d_signal), .rd_ch(rd_ch),
      .ctl_valid(ctl_valid), .adc_ack(adc_ack), .address(address), .busy(busy),
      .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
      .scan_done(scan_done), .err(err), .rd_data(rd_data)
   );

   always @(negedge clk)
      if (!rst && (result_valid || scan_done))
         mon_q.push_back({result_valid, scan_done, result_ch, result_data});

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_bank();
      for (int i = 0; i < 8; i++) begin
         rd_ch = 3'(i);
         #1;
         chk("rd_data", 32'(rd_data), 32'(bank_m[i]));
      end
   endtask

   // Capture block: one conversion with random latencies and full ready/ack handshake.
   task automatic do_conv(output logic [2:0] a, output logic [11:0] d);
      int t;
      repeat ($urandom_range(0, 3)) tick();
      chk("ctl_valid_on", 32'(ctl_valid), 1);
      a = address;
      d = 12'($urandom);
      d_signal  = d;
      adc_ready = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!adc_ack && t < 8);
      chk("ack_rise", 32'(adc_ack), 1);
      repeat ($urandom_range(0, 2)) begin
         tick();
         chk("ack_hold", 32'(adc_ack), 1);
      end
      adc_ready = 1'b0;
      d_signal  = 12'($urandom);
      t = 0;
      do begin tick(); t++; end while (adc_ack && t < 4);
      chk("ack_fall", 32'(adc_ack), 0);
   endtask

   // Single pass: one conversion per enabled channel plus the discarded priming one.
   // Continuous: n_cont conversions, then a stop in WAIT costs exactly one more.
   task automatic run_scan(input logic [7:0] en, input bit cont, input int n_cont);
      logic [2:0]  chs[$];
      logic [16:0] exp_q[$];
      logic [2:0]  a, tag;
      logic [11:0] d;
      int          n, sz;
      for (int c = 0; c < 8; c++) if (en[c]) chs.push_back(3'(c));
      sz = chs.size();
      n  = cont ? n_cont : sz + 1;
      mon_q.delete();
      ch_enable = en; continuous = cont; start = 1'b1;
      tick();
      start = 1'b0; ch_enable = 8'($urandom); continuous = ~cont;
      chk("start_busy", 32'(busy), 1);
      chk("start_err_clr", 32'(err), 0);
      for (int i = 0; i <= n; i++) begin
         if (i == n) begin
            if (!cont) break;
            stop = 1'b1; tick(); stop = 1'b0;
         end
         do_conv(a, d);
         chk("addr_seq", 32'(a), 32'(chs[i % sz]));
         if (i > 0) begin
            tag = chs[(i - 1) % sz];
            exp_q.push_back({1'b1, tag == chs[sz - 1], tag, d});
            bank_m[tag] = d;
         end
      end
      chk("end_busy", 32'(busy), 0);
      chk("end_ctl_valid", 32'(ctl_valid), 0);
      tick();
      chk("n_results", 32'(mon_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk("result", 32'(mon_q[i]), 32'(exp_q[i]));
      chk_bank();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] en;
      rst = 1'b1; start = 0; stop = 0; continuous = 0; ch_enable = 0;
      adc_ready = 0; d_signal = 0; rd_ch = 0;
      for (int i = 0; i < 8; i++) bank_m[i] = '0;
      tick(); tick();
      chk("rst_outs", 32'({ctl_valid, adc_ack, busy, result_valid, scan_done, err, address, result_ch, result_data}), 0);
      chk_bank();
      rst = 1'b0;
      tick();

      run_scan(8'b1010_0101, 1'b0, 0);
      run_scan(8'h08, 1'b1, 3);
      chk("addr_hold", 32'(address), 3);
      for (int k = 0; k < 6; k++)
         run_scan(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), $urandom_range(2, 9));

      // Timeout from PRIME, then empty-mask start, then a clearing start and stop+timeout collision.
      ch_enable = 8'($urandom_range(1, 255)); start = 1'b1; tick(); start = 1'b0;
      repeat (15) tick();
      chk("tmo_pre_err", 32'(err), 0);
      chk("tmo_pre_ctl", 32'(ctl_valid), 1);
      tick();
      chk("tmo_err", 32'(err), 1);
      chk("tmo_ctl", 32'(ctl_valid), 0);
      chk("tmo_busy", 32'(busy), 0);
      ch_enable = 8'h00; start = 1'b1; tick(); start = 1'b0;
      chk("zero_en_busy", 32'(busy), 0);
      chk("zero_en_ctl", 32'(ctl_valid), 0);
      chk("zero_en_err", 32'(err), 1);
      ch_enable = 8'($urandom_range(1, 255)); start = 1'b1; tick(); start = 1'b0;
      chk("restart_err", 32'(err), 0);
      chk("restart_busy", 32'(busy), 1);
      repeat (15) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      chk("stop_tmo_err", 32'(err), 1);
      chk("stop_tmo_busy", 32'(busy), 0);

      for (int k = 0; k < 2; k++)
         run_scan(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), $urandom_range(2, 6));

      // Reset asserted while the sequencer is holding adc_ack.
      en = 8'($urandom_range(1, 255));
      ch_enable = en; continuous = 1'b1; start = 1'b1; tick(); start = 1'b0;
      adc_ready = 1'b1; d_signal = 12'($urandom);
      tick();
      chk("pre_rst_ack", 32'(adc_ack), 1);
      rst = 1'b1;
      #1;
      chk("rst_ack_outs", 32'({ctl_valid, adc_ack, busy, result_valid, scan_done, err, address, result_ch, result_data}), 0);
      for (int i = 0; i < 8; i++) bank_m[i] = '0;
      chk_bank();
      tick();
      mon_q.delete();
      adc_ready = 1'b0;
      rst = 1'b0;
      repeat (4) tick();
      chk("post_rst_strobes", 32'(mon_q.size()), 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
